// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C request arbiter: FSM states and the latched command payload.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        wr;
        logic        addr_2byte;
        logic [7:0]  dev_addr;
        logic [15:0] reg_addr;
        logic [7:0]  wdata;
    } i2c_cmd_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic               found,
    output logic [GW-1:0]      idx
);

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return GW'(s);
    endfunction

    always_comb begin
        logic [GW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ register-access clients.
// Latches the winning command, runs the master handshake and returns the result to the winner.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
    localparam int unsigned GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ-1:0]    req_addr_2byte,
    input  logic [NUM_REQ*8-1:0]  req_dev_addr,
    input  logic [NUM_REQ*16-1:0] req_reg_addr,
    input  logic [NUM_REQ*8-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    output logic                  m_read_req,
    output logic                  m_write_req,
    input  logic                  m_read_req_ack,
    input  logic                  m_write_req_ack,
    output logic                  m_addr_2byte,
    output logic [7:0]            m_dev_addr,
    output logic [15:0]           m_reg_addr,
    output logic [7:0]            m_wdata,
    input  logic [7:0]            m_rdata,
    input  logic                  m_error,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic [7:0]            err_count,
    output logic                  hang
);

    state_t               state_q, state_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    i2c_cmd_t             cmd_q, cmd_d;
    logic                 m_read_req_q, m_read_req_d;
    logic                 m_write_req_q, m_write_req_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [7:0]           rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 hang_q, hang_d;
    logic                 busy_q, busy_d;
    logic [23:0]          wdog_q, wdog_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    i2c_cmd_t             pick_cmd_c;
    logic                 ack_ok_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Field slice of the candidate client
    always_comb begin
        pick_cmd_c.wr         = req_wr[pick_idx];
        pick_cmd_c.addr_2byte = req_addr_2byte[pick_idx];
        pick_cmd_c.dev_addr   = req_dev_addr[{pick_idx, 3'b000} +: 8];
        pick_cmd_c.reg_addr   = req_reg_addr[{pick_idx, 4'b0000} +: 16];
        pick_cmd_c.wdata      = req_wdata[{pick_idx, 3'b000} +: 8];
    end

    // Only the ack matching the issued request type completes the transfer
    assign ack_ok_c = cmd_q.wr ? (m_write_req_q & m_write_req_ack)
                               : (m_read_req_q & m_read_req_ack);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        cmd_d         = cmd_q;
        m_read_req_d  = m_read_req_q;
        m_write_req_d = m_write_req_q;
        req_ack_d     = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        err_count_d   = err_count_q;
        hang_d        = hang_q;
        wdog_d        = wdog_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    cmd_d         = pick_cmd_c;
                    grant_id_d    = pick_idx;
                    m_write_req_d = pick_cmd_c.wr;
                    m_read_req_d  = ~pick_cmd_c.wr;
                    wdog_d        = '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                // Watchdog only flags; the transfer keeps waiting for its ack
                if (wdog_q != TIMEOUT_CYC) begin
                    wdog_d = wdog_q + 24'd1;
                end
                if (wdog_d == TIMEOUT_CYC) begin
                    hang_d = 1'b1;
                end
                if (ack_ok_c) begin
                    m_read_req_d          = 1'b0;
                    m_write_req_d         = 1'b0;
                    rsp_rdata_d           = m_rdata;
                    rsp_err_d             = m_error;
                    if (m_error) begin
                        err_count_d = sat_inc8(err_count_q);
                    end
                    req_ack_d[grant_id_q] = 1'b1;
                    state_d               = DONE;
                end
            end
            DONE: begin
                ptr_d   = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            cmd_q         <= '0;
            m_read_req_q  <= 1'b0;
            m_write_req_q <= 1'b0;
            req_ack_q     <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            err_count_q   <= '0;
            hang_q        <= 1'b0;
            busy_q        <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            cmd_q         <= cmd_d;
            m_read_req_q  <= m_read_req_d;
            m_write_req_q <= m_write_req_d;
            req_ack_q     <= req_ack_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            err_count_q   <= err_count_d;
            hang_q        <= hang_d;
            busy_q        <= busy_d;
            wdog_q        <= wdog_d;
        end
    end

    assign req_ack      = req_ack_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign m_read_req   = m_read_req_q;
    assign m_write_req  = m_write_req_q;
    assign m_addr_2byte = cmd_q.addr_2byte;
    assign m_dev_addr   = cmd_q.dev_addr;
    assign m_reg_addr   = cmd_q.reg_addr;
    assign m_wdata      = cmd_q.wdata;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign err_count    = err_count_q;
    assign hang         = hang_q;

endmodule
